alu_exec_unit: RTL and testbench

- Parametrised sequential successor to the board-level ALU datapath. One clocked unit holds operand registers A and B, result Y and status flags.
- Raw push-button inputs are synchronised and debounced. Each press is turned into exactly one command.
- Single-cycle ALU ops execute alongside a multi-cycle shift-add multiplier, with busy/done status.
- Sits between switches/buttons and the seven-segment/LED display logic at top level.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_exec_unit_if.sv | 26 ++
 rtl/button_debounce.sv | 54 +++++
 rtl/alu_exec_unit.sv | 211 +++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag-index definitions for the ALU execution unit.
package alu_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NOP   = 4'd0;
  localparam opcode_t OP_LDA   = 4'd1;
  localparam opcode_t OP_LDB   = 4'd2;
  localparam opcode_t OP_SWAP  = 4'd3;
  localparam opcode_t OP_ADD   = 4'd4;
  localparam opcode_t OP_SUB   = 4'd5;
  localparam opcode_t OP_AND   = 4'd6;
  localparam opcode_t OP_OR    = 4'd7;
  localparam opcode_t OP_XOR   = 4'd8;
  localparam opcode_t OP_NOTA  = 4'd9;
  localparam opcode_t OP_SHL   = 4'd10;
  localparam opcode_t OP_SHR   = 4'd11;
  localparam opcode_t OP_MUL   = 4'd12;
  localparam opcode_t OP_MOVYA = 4'd13;
  localparam opcode_t OP_CLRY  = 4'd14;
  localparam opcode_t OP_RSVD  = 4'd15;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StMul  = 2'd2
  } state_e;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Button/switch inputs and register/status outputs of the ALU execution unit.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             trigger_btn;
  logic             clear_btn;
  logic [3:0]       op;
  logic [WIDTH-1:0] ext_in;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [WIDTH-1:0] y_out;
  logic [WIDTH-1:0] y_hi;
  logic [3:0]       flags;
  logic             busy;
  logic             done;

  modport master (
    output trigger_btn, clear_btn, op, ext_in,
    input  a_out, b_out, y_out, y_hi, flags, busy, done
  );

  modport slave (
    input  trigger_btn, clear_btn, op, ext_in,
    output a_out, b_out, y_out, y_hi, flags, busy, done
  );
endinterface

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus counter debounce; emits a one-cycle pulse on each accepted press.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned CNT_BITS        = 17
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);

  localparam logic [CNT_BITS-1:0] CntLast = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic                sync1_q, sync2_q;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                rise_q, rise_d;

  // Level flips on the DEBOUNCE_CYCLES-th consecutive mismatch; any agreeing cycle restarts.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Sequential ALU: operand/result registers, single-cycle ops and a shift-add multiplier,
// driven by a debounced execute button and a synchronised clear button.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned CNT_BITS        = 17
) (
  input  logic           clk,
  input  logic           reset_n,
  alu_exec_unit_if.slave io
);

  localparam int unsigned        MulCntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [MulCntW-1:0] MulLast = MulCntW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   ext_q, ext_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, y_q, y_d, yh_q, yh_d;
  logic [WIDTH-1:0]   mhi_q, mhi_d, mlo_q, mlo_d;
  logic [MulCntW-1:0] mcnt_q, mcnt_d;
  logic [3:0]         flags_q, flags_d;
  logic               done_q, done_d;
  logic               clr_s1_q, clr_s2_q;

  logic               start, trig_level_unused;
  logic [WIDTH:0]     add_w, sub_w, mul_sum;
  logic [WIDTH-1:0]   res, mul_hi_n, mul_lo_n;
  logic               res_c, res_v, res_wr;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_BITS       (CNT_BITS)
  ) u_trig_db (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_raw   (io.trigger_btn),
    .level     (trig_level_unused),
    .rise_pulse(start)
  );

  // Result datapath for the single-cycle ops and one shift-add step of the multiplier.
  always_comb begin
    add_w    = {1'b0, a_q} + {1'b0, b_q};
    sub_w    = {1'b0, a_q} - {1'b0, b_q};
    mul_sum  = {1'b0, mhi_q} + (mlo_q[0] ? {1'b0, a_q} : '0);
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], mlo_q[WIDTH-1:1]};
    res      = '0;
    res_c    = 1'b0;
    res_v    = 1'b0;
    res_wr   = 1'b1;
    case (op_q)
      OP_ADD: begin
        res   = add_w[WIDTH-1:0];
        res_c = add_w[WIDTH];
        res_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res   = sub_w[WIDTH-1:0];
        res_c = sub_w[WIDTH];
        res_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  res = a_q & b_q;
      OP_OR:   res = a_q | b_q;
      OP_XOR:  res = a_q ^ b_q;
      OP_NOTA: res = ~a_q;
      OP_SHL: begin
        res   = {a_q[WIDTH-2:0], 1'b0};
        res_c = a_q[WIDTH-1];
      end
      OP_SHR: begin
        res   = {1'b0, a_q[WIDTH-1:1]};
        res_c = a_q[0];
      end
      default: res_wr = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ext_d   = ext_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    yh_d    = yh_q;
    flags_d = flags_q;
    mhi_d   = mhi_q;
    mlo_d   = mlo_q;
    mcnt_d  = mcnt_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          op_d  = io.op;
          ext_d = io.ext_in;
          if (io.op == OP_MUL) begin
            state_d = StMul;
            mcnt_d  = '0;
            mhi_d   = '0;
            mlo_d   = b_q;
          end else begin
            state_d = StExec;
          end
        end
      end
      StExec: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (res_wr) begin
          y_d             = res;
          yh_d            = '0;
          flags_d[FLAG_N] = res[WIDTH-1];
          flags_d[FLAG_V] = res_v;
          flags_d[FLAG_C] = res_c;
          flags_d[FLAG_Z] = (res == '0);
        end
        case (op_q)
          OP_LDA:   a_d = ext_q;
          OP_LDB:   b_d = ext_q;
          OP_SWAP: begin
            a_d = b_q;
            b_d = a_q;
          end
          OP_MOVYA: a_d = y_q;
          OP_CLRY: begin
            y_d     = '0;
            yh_d    = '0;
            flags_d = '0;
          end
          default: ;
        endcase
      end
      StMul: begin
        mhi_d  = mul_hi_n;
        mlo_d  = mul_lo_n;
        mcnt_d = mcnt_q + MulCntW'(1);
        if (mcnt_q == MulLast) begin
          state_d         = StIdle;
          done_d          = 1'b1;
          y_d             = mul_lo_n;
          yh_d            = mul_hi_n;
          flags_d[FLAG_N] = mul_hi_n[WIDTH-1];
          flags_d[FLAG_V] = 1'b0;
          flags_d[FLAG_C] = |mul_hi_n;
          flags_d[FLAG_Z] = ({mul_hi_n, mul_lo_n} == '0);
        end
      end
      default: state_d = StIdle;
    endcase

    // Clear wins over any start or completion, aborting an in-flight multiply.
    if (clr_s2_q) begin
      state_d = StIdle;
      a_d     = '0;
      b_d     = '0;
      y_d     = '0;
      yh_d    = '0;
      flags_d = '0;
      mcnt_d  = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      ext_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      y_q      <= '0;
      yh_q     <= '0;
      flags_q  <= '0;
      mhi_q    <= '0;
      mlo_q    <= '0;
      mcnt_q   <= '0;
      done_q   <= 1'b0;
      clr_s1_q <= 1'b0;
      clr_s2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ext_q    <= ext_d;
      a_q      <= a_d;
      b_q      <= b_d;
      y_q      <= y_d;
      yh_q     <= yh_d;
      flags_q  <= flags_d;
      mhi_q    <= mhi_d;
      mlo_q    <= mlo_d;
      mcnt_q   <= mcnt_d;
      done_q   <= done_d;
      clr_s1_q <= io.clear_btn;
      clr_s2_q <= clr_s1_q;
    end
  end

  assign io.a_out = a_q;
  assign io.b_out = b_q;
  assign io.y_out = y_q;
  assign io.y_hi  = yh_q;
  assign io.flags = flags_q;
  assign io.busy  = (state_q != StIdle);
  assign io.done  = done_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: an arithmetic reference model checked every idle cycle,
// plus literal expectations for the headline cases.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(W)) io ();

  alu_exec_unit #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(4),
    .CNT_BITS       (3)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .io     (io)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference state: committed values and the pending command's outcome.
  logic [7:0] cur_a, cur_b, cur_y, cur_yh, pnd_a, pnd_b, pnd_y, pnd_yh;
  logic [3:0] cur_f, pnd_f;
  bit         pend     = 1'b0;
  bit         check_en = 1'b0;
  int         exp_len  = 0;
  int         done_cnt = 0;
  int         busy_len = 0;
  bit         busy_prev = 1'b0;

  function automatic int sx(input logic [7:0] x);
    return (x >= 8'd128) ? int'(x) - 256 : int'(x);
  endfunction

  task automatic model_cmd(input logic [3:0] op, input logic [7:0] ext);
    int r, sr, p;
    bit c, v, wr;
    pnd_a = cur_a; pnd_b = cur_b; pnd_y = cur_y; pnd_yh = cur_yh; pnd_f = cur_f;
    r = 0; c = 1'b0; v = 1'b0; wr = 1'b1;
    exp_len = (op == OP_MUL) ? 8 : 1;
    case (op)
      OP_LDA:   begin pnd_a = ext; wr = 1'b0; end
      OP_LDB:   begin pnd_b = ext; wr = 1'b0; end
      OP_SWAP:  begin pnd_a = cur_b; pnd_b = cur_a; wr = 1'b0; end
      OP_ADD: begin
        r  = int'(cur_a) + int'(cur_b);
        c  = (r > 255);
        sr = sx(cur_a) + sx(cur_b);
        v  = (sr > 127) || (sr < -128);
      end
      OP_SUB: begin
        r  = int'(cur_a) - int'(cur_b);
        c  = (cur_a < cur_b);
        sr = sx(cur_a) - sx(cur_b);
        v  = (sr > 127) || (sr < -128);
      end
      OP_AND:   r = int'(cur_a & cur_b);
      OP_OR:    r = int'(cur_a | cur_b);
      OP_XOR:   r = int'(cur_a ^ cur_b);
      OP_NOTA:  r = 255 - int'(cur_a);
      OP_SHL:   begin r = int'(cur_a) * 2; c = (cur_a >= 8'd128); end
      OP_SHR:   begin r = int'(cur_a) / 2; c = (int'(cur_a) % 2 == 1); end
      OP_MUL: begin
        p      = int'(cur_a) * int'(cur_b);
        pnd_y  = 8'(p % 256);
        pnd_yh = 8'(p / 256);
        pnd_f  = {p >= 32768, 1'b0, p >= 256, p == 0};
        wr     = 1'b0;
      end
      OP_MOVYA: begin pnd_a = cur_y; wr = 1'b0; end
      OP_CLRY:  begin pnd_y = 8'h00; pnd_yh = 8'h00; pnd_f = 4'h0; wr = 1'b0; end
      default:  wr = 1'b0;
    endcase
    if (wr) begin
      r      = r & 255;
      pnd_y  = 8'(r);
      pnd_yh = 8'h00;
      pnd_f  = {r >= 128, v, c, r == 0};
    end
    pend = 1'b1;
  endtask

  always @(negedge clk) if (reset_n && io.done) done_cnt++;

  // Compare process: done timing against busy, and register contents whenever idle.
  always @(negedge clk) begin
    if (!reset_n) begin
      busy_prev = 1'b0;
      busy_len  = 0;
    end else begin
      if (check_en) begin
        if (!io.busy && busy_prev) begin
          chk("busy_len", busy_len, exp_len);
          chk("done_after_busy", 32'(io.done), 32'd1);
        end
        if (io.busy) chk("done_while_busy", 32'(io.done), 32'd0);
        if (io.done && !pend) chk("unexpected_done", 32'(io.done), 32'd0);
        if (io.done && pend) begin
          cur_a = pnd_a; cur_b = pnd_b; cur_y = pnd_y; cur_yh = pnd_yh; cur_f = pnd_f;
          pend  = 1'b0;
        end
        if (!io.busy) begin
          chk("a_out", 32'(io.a_out), 32'(cur_a));
          chk("b_out", 32'(io.b_out), 32'(cur_b));
          chk("y_out", 32'(io.y_out), 32'(cur_y));
          chk("y_hi", 32'(io.y_hi), 32'(cur_yh));
          chk("flags", 32'(io.flags), 32'(cur_f));
        end
      end
      if (io.busy) busy_len++;
      else busy_len = 0;
      busy_prev = io.busy;
    end
  end

  task automatic launch(input logic [3:0] op, input logic [7:0] ext);
    bit ok;
    ok = 1'b0;
    model_cmd(op, ext);
    io.op          = op;
    io.ext_in      = ext;
    io.trigger_btn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (io.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("busy_timeout", 32'(io.busy), 32'd1);
  endtask

  task automatic cmd(input logic [3:0] op, input logic [7:0] ext, input bit glitch);
    int d0;
    d0 = done_cnt;
    launch(op, ext);
    if (glitch) begin
      io.trigger_btn = 1'b0;
      @(negedge clk);
      io.trigger_btn = 1'b1;
    end
    for (int i = 0; i < 40 && done_cnt == d0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    io.trigger_btn = 1'b0;
    repeat (10) @(negedge clk);
    chk("done_count", done_cnt - d0, 1);
  endtask

  task automatic zero_model();
    cur_a = '0; cur_b = '0; cur_y = '0; cur_yh = '0; cur_f = '0;
    pend  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"}, 32'(io.a_out), 32'd0);
    chk({tag, "_b"}, 32'(io.b_out), 32'd0);
    chk({tag, "_y"}, 32'(io.y_out), 32'd0);
    chk({tag, "_yh"}, 32'(io.y_hi), 32'd0);
    chk({tag, "_flags"}, 32'(io.flags), 32'd0);
    chk({tag, "_busy"}, 32'(io.busy), 32'd0);
    chk({tag, "_done"}, 32'(io.done), 32'd0);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] ext;
    logic [7:0] y;
    logic [3:0] f;
  } vec_t;
  vec_t tbl [13];

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    // Starting from A=05, B=03, Y=FE, flags=A after the SWAP step.
    tbl = '{
      '{OP_AND,   8'h00, 8'h01, 4'h0},
      '{OP_OR,    8'h00, 8'h07, 4'h0},
      '{OP_XOR,   8'h00, 8'h06, 4'h0},
      '{OP_NOTA,  8'h00, 8'hFA, 4'h8},
      '{OP_SHL,   8'h00, 8'h0A, 4'h0},
      '{OP_SHR,   8'h00, 8'h02, 4'h2},
      '{OP_MOVYA, 8'h00, 8'h02, 4'h2},
      '{OP_SHR,   8'h00, 8'h01, 4'h0},
      '{OP_LDA,   8'h80, 8'h01, 4'h0},
      '{OP_SHL,   8'h00, 8'h00, 4'h3},
      '{OP_CLRY,  8'h00, 8'h00, 4'h0},
      '{OP_NOP,   8'h3C, 8'h00, 4'h0},
      '{OP_RSVD,  8'hC3, 8'h00, 4'h0}
    };
    io.trigger_btn = 1'b0;
    io.clear_btn   = 1'b0;
    io.op          = '0;
    io.ext_in      = '0;
    zero_model();

    #13;
    chk_all_zero("reset");
    #10 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_en = 1'b1;

    // Bounce rejection: toggle every 2 cycles for 20 cycles.
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) begin
      io.trigger_btn = ~io.trigger_btn;
      repeat (2) @(negedge clk);
    end
    io.trigger_btn = 1'b0;
    repeat (8) @(negedge clk);
    chk("bounce_no_done", done_cnt, d0);
    cmd(OP_LDA, 8'h11, 1'b0);
    chk("bounce_lda_a", 32'(io.a_out), 32'h11);

    cmd(OP_LDA, 8'h7F, 1'b0);
    cmd(OP_LDB, 8'h01, 1'b0);
    cmd(OP_ADD, 8'h00, 1'b0);
    chk("add_y", 32'(io.y_out), 32'h80);
    chk("add_flags", 32'(io.flags), 32'hC);

    cmd(OP_LDA, 8'h03, 1'b0);
    cmd(OP_LDB, 8'h05, 1'b0);
    cmd(OP_SUB, 8'h00, 1'b0);
    chk("sub_y", 32'(io.y_out), 32'hFE);
    chk("sub_flags", 32'(io.flags), 32'hA);
    cmd(OP_SWAP, 8'h00, 1'b0);
    chk("swap_a", 32'(io.a_out), 32'h05);
    chk("swap_b", 32'(io.b_out), 32'h03);
    chk("swap_flags", 32'(io.flags), 32'hA);

    foreach (tbl[i]) begin
      cmd(tbl[i].op, tbl[i].ext, 1'b0);
      chk($sformatf("tbl%0d_y", i), 32'(io.y_out), 32'(tbl[i].y));
      chk($sformatf("tbl%0d_flags", i), 32'(io.flags), 32'(tbl[i].f));
    end

    // Multiply with a re-press glitch while busy.
    cmd(OP_LDA, 8'hFF, 1'b0);
    cmd(OP_LDB, 8'hFF, 1'b0);
    cmd(OP_MUL, 8'h00, 1'b1);
    chk("mul_yhi", 32'(io.y_hi), 32'hFE);
    chk("mul_y", 32'(io.y_out), 32'h01);
    chk("mul_flags", 32'(io.flags), 32'hA);

    // Clear pulse in the 4th multiply cycle aborts the command.
    cmd(OP_LDA, 8'h06, 1'b0);
    cmd(OP_LDB, 8'h07, 1'b0);
    launch(OP_MUL, 8'h00);
    check_en = 1'b0;
    pend     = 1'b0;
    d0       = done_cnt;
    repeat (3) @(negedge clk);
    io.clear_btn = 1'b1;
    @(negedge clk);
    io.clear_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("clear");
    repeat (12) @(negedge clk);
    chk("clear_no_done", done_cnt, d0);
    io.trigger_btn = 1'b0;
    repeat (8) @(negedge clk);
    zero_model();
    check_en = 1'b1;

    // Asynchronous reset in the middle of an EXEC cycle.
    cmd(OP_LDA, 8'h40, 1'b0);
    cmd(OP_LDB, 8'h40, 1'b0);
    launch(OP_ADD, 8'h00);
    check_en = 1'b0;
    pend     = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    io.trigger_btn = 1'b0;
    repeat (3) @(negedge clk);
    #3 reset_n = 1'b1;
    zero_model();
    repeat (4) @(negedge clk);
    check_en = 1'b1;
    cmd(OP_LDA, 8'h5A, 1'b0);
    cmd(OP_LDB, 8'h21, 1'b0);
    cmd(OP_ADD, 8'h00, 1'b0);
    chk("post_reset_y", 32'(io.y_out), 32'h7B);
    chk("post_reset_flags", 32'(io.flags), 32'h0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
